// File: rtl/seq_match_detector_pkg.sv
// Shared types and constants for the sequence-match detector and the display counter stage.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT0  = 2'b01,
        ARMED = 2'b10
    } state_t;

    localparam int COUNT_W = 6;

    // Segment pattern {g,f,e,d,c,b,a}, active-high, for the downstream 7-segment display.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/seq_match_detector_btn_debounce.sv
// Synchronises the raw step button and serial bit, debounces the button and
// emits a one-cycle strobe on each debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_bit,
    output logic o_strobe,
    output logic o_bit
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_btn_p0, r_btn_p1;
    logic             r_bit_p0, r_bit_p1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_p0  <= 1'b0;
            r_btn_p1  <= 1'b0;
            r_bit_p0  <= 1'b0;
            r_bit_p1  <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop synchronisers
            r_btn_p0 <= i_btn;
            r_btn_p1 <= r_btn_p0;
            r_bit_p0 <= i_bit;
            r_bit_p1 <= r_bit_p0;
            // level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
            if (r_btn_p1 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_strobe  <= r_level & ~r_level_d;
        end
    end

    assign o_strobe = r_strobe;
    assign o_bit    = r_bit_p1;

endmodule

// File: rtl/seq_match_detector.sv
// Mealy detector for 01[0*]1 on debounced step-button bits, with a wrapping match counter.
// Optional macro SEQ_OVERLAP_EN: a match ending in "01" re-arms instead of returning to IDLE.
import seq_pkg::*;

module seq_match_detector #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int COUNT_MAX       = 63
) (
    input  logic               clk_50MHz,
    input  logic               rst,
    input  logic               bit_in,
    input  logic               step_btn,
    input  logic               clear_count,
    output logic               match_pulse,
    output logic [COUNT_W-1:0] match_count,
    output logic [1:0]         fsm_state_show,
    output logic               bit_accept_show
);

    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(COUNT_MAX);

    function automatic logic [COUNT_W-1:0] wrap_inc(input logic [COUNT_W-1:0] c);
        return (c == COUNT_LAST) ? '0 : c + 1'b1;
    endfunction

    logic               w_strobe;
    logic               w_bit;
    state_t             r_state;
    state_t             w_state_next;
    logic               w_match;
    logic               r_match;
    logic [COUNT_W-1:0] r_count;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk_50MHz),
        .rst     (rst),
        .i_btn   (step_btn),
        .i_bit   (bit_in),
        .o_strobe(w_strobe),
        .o_bit   (w_bit)
    );

`ifdef SEQ_OVERLAP_EN
    // previous accepted bit; reset to 1 so no phantom "0" precedes the first bit
    logic r_prev_bit;

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_prev_bit <= 1'b1;
        end else if (w_strobe) begin
            r_prev_bit <= w_bit;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_match      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_strobe && !w_bit) w_state_next = GOT0;
            end
            GOT0: begin
                if (w_strobe && w_bit) w_state_next = ARMED;
            end
            ARMED: begin
                if (w_strobe && w_bit) begin
                    w_match = 1'b1;
`ifdef SEQ_OVERLAP_EN
                    w_state_next = r_prev_bit ? IDLE : ARMED;
`else
                    w_state_next = IDLE;
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_state <= IDLE;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_match <= w_match;
            // clear has priority over a coincident increment
            if (clear_count) begin
                r_count <= '0;
            end else if (w_match) begin
                r_count <= wrap_inc(r_count);
            end
        end
    end

    assign match_pulse     = r_match;
    assign match_count     = r_count;
    assign fsm_state_show  = r_state;
    assign bit_accept_show = w_strobe;

endmodule

// File: tb/tb_seq_match_detector.sv
// Directed table-driven bench for seq_match_detector at DEBOUNCE_CYCLES=2, COUNT_MAX=63.
module tb_seq_match_detector;

    logic       clk_50MHz = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       step_btn = 1'b0;
    logic       clear_count = 1'b0;
    logic       match_pulse;
    logic [5:0] match_count;
    logic [1:0] fsm_state_show;
    logic       bit_accept_show;

    int errors = 0;
    int checks = 0;

    seq_match_detector #(
        .DEBOUNCE_CYCLES(2),
        .COUNT_MAX(63)
    ) dut (
        .clk_50MHz      (clk_50MHz),
        .rst            (rst),
        .bit_in         (bit_in),
        .step_btn       (step_btn),
        .clear_count    (clear_count),
        .match_pulse    (match_pulse),
        .match_count    (match_count),
        .fsm_state_show (fsm_state_show),
        .bit_accept_show(bit_accept_show)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    typedef struct {
        logic       b;
        logic [1:0] st;
        logic       m;
        logic [5:0] cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One button press carrying bit b; samples the strobe cycle and the cycle after it.
    task automatic press(input logic b, input logic clr, output int lat,
                         output logic [1:0] st_dur, output logic m_dur,
                         output logic [1:0] st_aft, output logic m_aft,
                         output logic [5:0] c_aft, output logic s_aft);
        bit_in = b;
        repeat (3) @(negedge clk_50MHz);
        step_btn = 1'b1;
        lat = 0;
        do begin
            @(negedge clk_50MHz);
            lat++;
        end while (!bit_accept_show && lat < 20);
        st_dur = fsm_state_show;
        m_dur  = match_pulse;
        if (clr) clear_count = 1'b1;
        @(negedge clk_50MHz);
        clear_count = 1'b0;
        st_aft = fsm_state_show;
        m_aft  = match_pulse;
        c_aft  = match_count;
        s_aft  = bit_accept_show;
        step_btn = 1'b0;
        repeat (6) @(negedge clk_50MHz);
    endtask

    int         lat;
    logic [1:0] st_dur, st_aft, prev_st;
    logic       m_dur, m_aft, s_aft;
    logic [5:0] c_aft;
    logic       seen;

    initial begin
        tbl[0] = '{1'b0, 2'b01, 1'b0, 6'd0};
        tbl[1] = '{1'b1, 2'b10, 1'b0, 6'd0};
        tbl[2] = '{1'b1, 2'b00, 1'b1, 6'd1};
        tbl[3] = '{1'b0, 2'b01, 1'b0, 6'd1};
        tbl[4] = '{1'b1, 2'b10, 1'b0, 6'd1};
        tbl[5] = '{1'b0, 2'b10, 1'b0, 6'd1};
        tbl[6] = '{1'b0, 2'b10, 1'b0, 6'd1};
        tbl[7] = '{1'b0, 2'b10, 1'b0, 6'd1};
`ifdef SEQ_OVERLAP_EN
        tbl[8] = '{1'b1, 2'b10, 1'b1, 6'd2};
        tbl[9] = '{1'b1, 2'b00, 1'b1, 6'd3};
`else
        tbl[8] = '{1'b1, 2'b00, 1'b1, 6'd2};
        tbl[9] = '{1'b1, 2'b00, 1'b0, 6'd2};
`endif

        // reset state
        repeat (3) @(negedge clk_50MHz);
        chk("rst_match_pulse", 32'(match_pulse), 32'd0);
        chk("rst_match_count", 32'(match_count), 32'd0);
        chk("rst_state", 32'(fsm_state_show), 32'd0);
        chk("rst_accept", 32'(bit_accept_show), 32'd0);
        rst = 1'b0;
        @(negedge clk_50MHz);

        // main table: 0,1,1 then 0,1,0,0,0,1,1
        prev_st = 2'b00;
        for (int i = 0; i < 10; i++) begin
            press(tbl[i].b, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
            chk($sformatf("v%0d_state_during", i), 32'(st_dur), 32'(prev_st));
            chk($sformatf("v%0d_match_during", i), 32'(m_dur), 32'd0);
            chk($sformatf("v%0d_state", i), 32'(st_aft), 32'(tbl[i].st));
            chk($sformatf("v%0d_match", i), 32'(m_aft), 32'(tbl[i].m));
            chk($sformatf("v%0d_count", i), 32'(c_aft), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_strobe_width", i), 32'(s_aft), 32'd0);
            prev_st = tbl[i].st;
        end

        // one-cycle glitch must not be accepted
        press(1'b0, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        chk("glitch_pre_state", 32'(st_aft), 32'd1);
        bit_in = 1'b1;
        repeat (3) @(negedge clk_50MHz);
        step_btn = 1'b1;
        @(negedge clk_50MHz);
        step_btn = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk_50MHz);
            if (bit_accept_show) seen = 1'b1;
        end
        chk("glitch_no_strobe", 32'(seen), 32'd0);
        chk("glitch_state", 32'(fsm_state_show), 32'd1);

        // reset while ARMED
        press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        chk("armed_before_rst", 32'(st_aft), 32'd2);
        rst = 1'b1;
        @(negedge clk_50MHz);
        rst = 1'b0;
        chk("midrst_state", 32'(fsm_state_show), 32'd0);
        chk("midrst_count", 32'(match_count), 32'd0);
        @(negedge clk_50MHz);

        // preload 63 matches, then wrap
        for (int k = 0; k < 63; k++) begin
            press(1'b0, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
            press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
            press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        end
        chk("preload_count", 32'(match_count), 32'd63);
        press(1'b0, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        chk("wrap_count", 32'(c_aft), 32'd0);
        chk("wrap_match", 32'(m_aft), 32'd1);

        // one ordinary match, then clear coinciding with a match
        press(1'b0, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        chk("post_wrap_count", 32'(c_aft), 32'd1);
        press(1'b0, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b1, 1'b1, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        chk("clr_match_count", 32'(c_aft), 32'd0);
        chk("clr_match_pulse", 32'(m_aft), 32'd1);

        // standalone clear leaves the FSM alone
        press(1'b0, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b1, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        press(1'b0, 1'b0, lat, st_dur, m_dur, st_aft, m_aft, c_aft, s_aft);
        chk("preclr_count", 32'(match_count), 32'd1);
        clear_count = 1'b1;
        @(negedge clk_50MHz);
        clear_count = 1'b0;
        chk("clr_count", 32'(match_count), 32'd0);
        chk("clr_state", 32'(fsm_state_show), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
